// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and sequencer in front of one shared combinational ALU.
// Define ALU_OP_CHECK_EN to treat opcode 3'b101 as reserved (forced to 0, flagged on rsp_err).
module alu_share_ctrl #(
  parameter int W           = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_c,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_c,
  output logic         rsp_zero,
  output logic         rsp_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EXEC     = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [2:0] OP_RSVD  = 3'b101;

`ifdef ALU_OP_CHECK_EN
  localparam logic OP_CHECK = 1'b1;
`else
  localparam logic OP_CHECK = 1'b0;
`endif

  logic [1:0]   state_r;
  logic [3:0]   cnt_r;
  logic         last_grant_r;
  logic         run_r;
  logic         err_pend_r;
  logic [W-1:0] alu_a_r;
  logic [W-1:0] alu_b_r;
  logic [2:0]   alu_op_r;
  logic         rsp_valid_r;
  logic         rsp_id_r;
  logic [W-1:0] rsp_c_r;
  logic         rsp_zero_r;
  logic         rsp_err_r;

  logic         grant_s;
  logic         grant_id_s;
  logic [W-1:0] sel_a_s;
  logic [W-1:0] sel_b_s;
  logic [2:0]   sel_op_s;
  logic         sel_illegal_s;

  // Arbitration: a tie goes to the requester that did not win last time.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    if ((state_r == IDLE) && run_r) begin
      if (req0_valid && req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = ~last_grant_r;
      end else if (req0_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b0;
      end else if (req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b1;
      end else begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
      end
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  // Operand select for the winning requester.
  always_comb begin
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    sel_op_s = req0_op;
    if (grant_id_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
    sel_illegal_s = OP_CHECK & (sel_op_s == OP_RSVD);
  end

  assign req0_ready = grant_s & ~grant_id_s;
  assign req1_ready = grant_s & grant_id_s;

  // Sequencer: latch operands on grant, count settle time, capture and hold the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= 1'b1;
      run_r        <= 1'b0;
      err_pend_r   <= 1'b0;
      alu_a_r      <= {W{1'b0}};
      alu_b_r      <= {W{1'b0}};
      alu_op_r     <= 3'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_c_r      <= {W{1'b0}};
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      run_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            alu_a_r      <= sel_a_s;
            alu_b_r      <= sel_b_s;
            alu_op_r     <= sel_illegal_s ? 3'd0 : sel_op_s;
            err_pend_r   <= sel_illegal_s;
            rsp_id_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
            cnt_r        <= CNT_LOAD;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            rsp_c_r     <= err_pend_r ? {W{1'b0}} : alu_c;
            rsp_zero_r  <= err_pend_r ? 1'b0 : alu_zero;
            rsp_err_r   <= err_pend_r;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_c     = rsp_c_r;
  assign rsp_zero  = rsp_zero_r;
  assign rsp_err   = rsp_err_r;

endmodule
